psum_drain: RTL and testbench

- Sits directly downstream of the bottom row of the systolic PE array and consumes the per-column partial_sum_out values.
- The array emits column k's result k cycles after column 0; this block deskews the columns into one aligned row.
- It then requantizes each ACC_WIDTH accumulator to OUT_WIDTH with rounding shift, optional ReLU and saturation.
- It buffers rows in a FIFO and drains them over a valid/ready stream, and raises a stall to the array controller before the FIFO can overflow.

---
 rtl/psum_drain.sv | 213 +++++++++++++++++++++
 tb/tb_psum_drain.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// Drain stage below the systolic array: deskews per-column partial sums into aligned rows,
// requantizes each lane, and streams rows out of a small FWFT FIFO with stall back-pressure.
module psum_drain #(
   parameter int N_COLS        = 4,
   parameter int ACC_WIDTH     = 16,
   parameter int OUT_WIDTH     = 8,
   parameter int FIFO_DEPTH    = 8,
   parameter int ROW_CNT_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [ROW_CNT_WIDTH-1:0]       cfg_rows,
   input  logic [3:0]                     cfg_shift,
   input  logic                           cfg_relu,
   input  logic [N_COLS*ACC_WIDTH-1:0]    psum_in,
   input  logic [N_COLS-1:0]              psum_valid,
   output logic                           array_stall,
   output logic [N_COLS*OUT_WIDTH-1:0]    out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           busy,
   output logic                           done,
   output logic                           skew_err,
   output logic                           ovf_err
);

   localparam int PW       = $clog2(FIFO_DEPTH);
   localparam int CW       = PW + 1;
   localparam int STALL_TH = FIFO_DEPTH - N_COLS - 1;
   localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [ACC_WIDTH:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic [ROW_CNT_WIDTH-1:0]    rows_q, row_cnt_q;
   logic [3:0]                  shift_q;
   logic                        relu_q;
   logic                        skew_err_q, ovf_err_q;
   logic                        start_acc, run;

   logic [N_COLS-1:0][ACC_WIDTH-1:0] dly_val;
   logic [N_COLS-1:0]                dly_vld;
   logic                             all_vld, any_vld;

   logic [N_COLS-1:0][ACC_WIDTH-1:0] al_q;
   logic                             al_vld_q;
   logic [N_COLS-1:0][OUT_WIDTH-1:0] rq_d, rq_q;
   logic                             rq_vld_q;

   logic [N_COLS*OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]               wptr_q, rptr_q;
   logic [CW-1:0]               cnt_q;
   logic                        push_req, full, pop, wr, ovf_set;
   logic [CW:0]                 occ;

   // Rounding arithmetic right shift, one guard bit so the rounding add cannot wrap.
   function automatic logic signed [ACC_WIDTH:0] round_shift(
      input logic signed [ACC_WIDTH-1:0] a,
      input logic [3:0]                  sh
   );
      logic signed [ACC_WIDTH:0] x;
      logic signed [ACC_WIDTH:0] rnd;
      x   = {a[ACC_WIDTH-1], a};
      rnd = '0;
      if (sh != 4'd0) rnd = (ACC_WIDTH+1)'(1) << (sh - 4'd1);
      return (x + rnd) >>> sh;
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] clamp(
      input logic signed [ACC_WIDTH:0] x,
      input logic                      relu
   );
      logic signed [ACC_WIDTH:0] y;
      y = (relu && x[ACC_WIDTH]) ? '0 : x;
      if (y > SAT_HI)      return SAT_HI[OUT_WIDTH-1:0];
      else if (y < SAT_LO) return SAT_LO[OUT_WIDTH-1:0];
      return y[OUT_WIDTH-1:0];
   endfunction

   assign start_acc = start && (state_q == S_IDLE);
   assign run       = (state_q == S_RUN);

   // Deskew: column k is delayed N_COLS-1-k cycles so all lanes of a row line up.
   for (genvar k = 0; k < N_COLS; k++) begin : g_col
      localparam int L = N_COLS - 1 - k;
      if (L == 0) begin : g_pass
         assign dly_val[k] = psum_in[k*ACC_WIDTH +: ACC_WIDTH];
         assign dly_vld[k] = psum_valid[k];
      end else begin : g_dly
         logic [ACC_WIDTH-1:0] val_q [L];
         logic [L-1:0]         vld_q;
         always_ff @(posedge clk) begin
            if (!rst_n || start_acc) begin
               for (int i = 0; i < L; i++) val_q[i] <= '0;
               vld_q <= '0;
            end else begin
               val_q[0] <= psum_in[k*ACC_WIDTH +: ACC_WIDTH];
               vld_q[0] <= psum_valid[k];
               for (int i = 1; i < L; i++) begin
                  val_q[i] <= val_q[i-1];
                  vld_q[i] <= vld_q[i-1];
               end
            end
         end
         assign dly_val[k] = val_q[L-1];
         assign dly_vld[k] = vld_q[L-1];
      end
   end

   assign all_vld = &dly_vld;
   assign any_vld = |dly_vld;

   // Aligned-row stage
   always_ff @(posedge clk) begin
      if (!rst_n || start_acc) begin
         al_q     <= '0;
         al_vld_q <= 1'b0;
      end else begin
         al_vld_q <= run && all_vld;
         if (run && all_vld) al_q <= dly_val;
      end
   end

   // Requantize stage
   always_comb begin
      rq_d = '0;
      for (int k = 0; k < N_COLS; k++) rq_d[k] = clamp(round_shift(al_q[k], shift_q), relu_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || start_acc) begin
         rq_q     <= '0;
         rq_vld_q <= 1'b0;
      end else begin
         rq_vld_q <= al_vld_q;
         if (al_vld_q) rq_q <= rq_d;
      end
   end

   // FIFO write stage; rows beyond the tile's row count are dropped before the FIFO.
   assign push_req = rq_vld_q && (row_cnt_q < rows_q);
   assign full     = (cnt_q == CW'(FIFO_DEPTH));
   assign pop      = (cnt_q != '0) && out_ready;
   assign wr       = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr) begin
            mem_q[wptr_q] <= rq_q;
            wptr_q        <= wptr_q + PW'(1);
         end
         if (pop) rptr_q <= rptr_q + PW'(1);
         if (wr && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (pop && !wr) cnt_q <= cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rows_q     <= '0;
         row_cnt_q  <= '0;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         skew_err_q <= 1'b0;
         ovf_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            rows_q     <= (cfg_rows == '0) ? ROW_CNT_WIDTH'(1) : cfg_rows;
            shift_q    <= cfg_shift;
            relu_q     <= cfg_relu;
            row_cnt_q  <= '0;
            skew_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
         end else begin
            if (wr) row_cnt_q <= row_cnt_q + ROW_CNT_WIDTH'(1);
            if (run && any_vld && !all_vld) skew_err_q <= 1'b1;
            if (ovf_set) ovf_err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (row_cnt_q == rows_q) state_d = S_FLUSH;
         S_FLUSH: if ((cnt_q == '0) && !al_vld_q && !rq_vld_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Occupancy counts rows already past alignment so the FIFO always has room for them.
   assign occ         = (CW+1)'(cnt_q) + (CW+1)'(al_vld_q) + (CW+1)'(rq_vld_q);
   assign array_stall = occ > (CW+1)'(STALL_TH);
   assign out_data    = mem_q[rptr_q];
   assign out_valid   = (cnt_q != '0);
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign skew_err    = skew_err_q;
   assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_psum_drain.sv
// Randomized bench for psum_drain: rows are launched with per-column skew and outputs are
// scored against a queue of rows requantized with plain integer arithmetic.
module tb_psum_drain;

   localparam int N     = 4;
   localparam int ACC_W = 16;
   localparam int OUT_W = 8;
   localparam int DEPTH = 8;
   localparam int RCW   = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [RCW-1:0]     cfg_rows = '0;
   logic [3:0]         cfg_shift = '0;
   logic               cfg_relu = 1'b0;
   logic [N*ACC_W-1:0] psum_in = '0;
   logic [N-1:0]       psum_valid = '0;
   logic               array_stall;
   logic [N*OUT_W-1:0] out_data;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic               busy, done, skew_err, ovf_err;

   psum_drain #(
      .N_COLS(N), .ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W),
      .FIFO_DEPTH(DEPTH), .ROW_CNT_WIDTH(RCW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
      .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .psum_in(psum_in),
      .psum_valid(psum_valid), .array_stall(array_stall), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
      .skew_err(skew_err), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int edge_no = 0;
   int done_cnt = 0;

   logic [N*ACC_W-1:0] row_data[$];
   int                 row_launch[$];
   int                 launch_q[$];
   int                 sched[N];
   logic [N*OUT_W-1:0] exp_q[$];

   bit         honour = 1'b1;
   bit         gaps = 1'b0;
   bit         manual = 1'b0;
   int         ready_mode = 0;
   logic [N-1:0] man_vld = '0;
   int         m_shift = 0;
   bit         m_relu = 1'b0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      else n_pass++;
   endtask

   function automatic int ref_rq(input int v, input int sh, input bit relu);
      int r;
      r = (sh > 0) ? v + (1 << (sh - 1)) : v;
      r = r >>> sh;
      if (relu && r < 0) r = 0;
      if (r > (1 << (OUT_W - 1)) - 1) r = (1 << (OUT_W - 1)) - 1;
      if (r < -(1 << (OUT_W - 1))) r = -(1 << (OUT_W - 1));
      return r;
   endfunction

   function automatic logic [N*OUT_W-1:0] pack_exp(input logic [N*ACC_W-1:0] row, input int sh,
                                                  input bit relu);
      logic [N*OUT_W-1:0] r;
      int v;
      r = '0;
      for (int k = 0; k < N; k++) begin
         v = int'($signed(row[k*ACC_W +: ACC_W]));
         r[k*OUT_W +: OUT_W] = OUT_W'(ref_rq(v, sh, relu));
      end
      return r;
   endfunction

   function automatic logic [N*ACC_W-1:0] rand_row();
      logic [N*ACC_W-1:0] r;
      for (int k = 0; k < N; k++) begin
         if ($urandom_range(0, 3) == 0) r[k*ACC_W +: ACC_W] = ACC_W'($urandom());
         else r[k*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(0, 1200)) - 600);
      end
      return r;
   endfunction

   task automatic add_row(input logic [N*ACC_W-1:0] row, input bit expect_out);
      row_data.push_back(row);
      row_launch.push_back(-1);
      launch_q.push_back(row_data.size() - 1);
      if (expect_out) exp_q.push_back(pack_exp(row, m_shift, m_relu));
   endtask

   task automatic step();
      logic [N*ACC_W-1:0] r;
      for (int k = N - 1; k > 0; k--) sched[k] = sched[k-1];
      sched[0] = -1;
      if (launch_q.size() > 0 && !(honour && array_stall) && !(gaps && $urandom_range(0, 2) == 0)) begin
         sched[0] = launch_q.pop_front();
         row_launch[sched[0]] = edge_no + 1;
      end
      psum_in    = {$urandom(), $urandom()};
      psum_valid = '0;
      for (int k = 0; k < N; k++) begin
         if (manual) psum_valid[k] = man_vld[k];
         else if (sched[k] >= 0) begin
            r = row_data[sched[k]];
            psum_valid[k] = 1'b1;
            psum_in[k*ACC_W +: ACC_W] = r[k*ACC_W +: ACC_W];
         end
      end
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk_eq("pop_unexpected", 64'(out_data), 64'h0 - 1);
         else chk_eq("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
      @(negedge clk);
      edge_no++;
      if (done) done_cnt++;
   endtask

   task automatic clear_model();
      row_data.delete();
      row_launch.delete();
      launch_q.delete();
      exp_q.delete();
      for (int k = 0; k < N; k++) sched[k] = -1;
   endtask

   task automatic start_tile(input int rows, input int sh, input bit relu);
      int n;
      n = 0;
      while (busy && n < 50) begin
         step();
         n++;
      end
      clear_model();
      m_shift   = sh;
      m_relu    = relu;
      cfg_rows  = RCW'(rows);
      cfg_shift = 4'(sh);
      cfg_relu  = relu;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         step();
         n++;
      end
      chk_eq(tag, 64'(done_cnt != d0), 64'd1);
   endtask

   initial begin
      logic [N*ACC_W-1:0] row;
      logic [N-1:0]       pat [5];
      int                 occ;
      int                 n;
      int                 rows;

      for (int k = 0; k < N; k++) sched[k] = -1;
      @(negedge clk);
      rst_n = 1'b0;
      step();
      step();
      chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
      chk_eq("rst_busy", 64'(busy), 64'd0);
      chk_eq("rst_done", 64'(done), 64'd0);
      chk_eq("rst_stall", 64'(array_stall), 64'd0);
      chk_eq("rst_errs", 64'({skew_err, ovf_err}), 64'd0);
      chk_eq("rst_out_data", 64'(out_data), 64'd0);
      rst_n = 1'b1;
      step();

      // single row with exact latency and done timing
      ready_mode = 0;
      start_tile(1, 0, 0);
      row = {16'd40, 16'd30, 16'd20, 16'd10};
      add_row(row, 1'b1);
      step();
      repeat (4) step();
      chk_eq("lat_early", 64'(out_valid), 64'd0);
      step();
      chk_eq("lat_on_time", 64'(out_valid), 64'd1);
      chk_eq("row_lanes", 64'(out_data), 64'({8'd40, 8'd30, 8'd20, 8'd10}));
      chk_eq("busy_run", 64'(busy), 64'd1);
      ready_mode = 1;
      step();
      chk_eq("empty_after_pop", 64'(out_valid), 64'd0);
      chk_eq("done_not_yet", 64'(done), 64'd0);
      step();
      chk_eq("done_pulse", 64'(done), 64'd1);
      step();
      chk_eq("done_one_cycle", 64'(done), 64'd0);
      chk_eq("idle_after_done", 64'(busy), 64'd0);

      // cfg_rows = 0 behaves as one row
      start_tile(0, 3, 0);
      add_row(rand_row(), 1'b1);
      wait_done(40, "rows0_done");
      chk_eq("rows0_drained", 64'(exp_q.size()), 64'd0);

      // rounding and saturation, without and with ReLU
      for (int rl = 0; rl < 2; rl++) begin
         ready_mode = 0;
         start_tile(1, 4, 1'(rl));
         add_row({16'(-5000), 16'(5000), 16'(-24), 16'(23)}, 1'b1);
         repeat (7) step();
         if (rl == 0) chk_eq("round_sat", 64'(out_data), 64'({8'h80, 8'h7F, 8'hFF, 8'h01}));
         else chk_eq("round_sat_relu", 64'(out_data), 64'({8'h00, 8'h7F, 8'h00, 8'h01}));
         ready_mode = 1;
         wait_done(40, "round_done");
      end

      // skew error: column 2 one cycle late
      ready_mode = 1;
      start_tile(1, 0, 0);
      pat = '{4'b0001, 4'b0010, 4'b0000, 4'b1100, 4'b0000};
      manual = 1'b1;
      for (int i = 0; i < 5; i++) begin
         man_vld = pat[i];
         step();
      end
      manual  = 1'b0;
      man_vld = '0;
      repeat (4) step();
      chk_eq("skew_err_set", 64'(skew_err), 64'd1);
      chk_eq("skew_no_push", 64'(out_valid), 64'd0);
      chk_eq("skew_still_run", 64'(busy), 64'd1);
      add_row(rand_row(), 1'b1);
      wait_done(40, "skew_recover_done");
      chk_eq("skew_sticky", 64'(skew_err), 64'd1);
      start_tile(1, 1, 1);
      chk_eq("start_clears_skew", 64'(skew_err), 64'd0);
      add_row(rand_row(), 1'b1);
      wait_done(40, "post_skew_done");

      // backpressure with the stall honoured
      ready_mode = 0;
      honour     = 1'b1;
      start_tile(12, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 12; i++) add_row(rand_row(), 1'b1);
      for (int i = 0; i < 30; i++) begin
         if (i == 10) begin
            start     = 1'b1;
            cfg_shift = ~cfg_shift;
            cfg_rows  = 8'd1;
         end
         step();
         start = 1'b0;
         occ = 0;
         foreach (row_launch[j]) if (row_launch[j] >= 0 && row_launch[j] + 3 <= edge_no) occ++;
         chk_eq("stall_model", 64'(array_stall), 64'(occ > DEPTH - N - 1));
      end
      chk_eq("bp_no_ovf", 64'(ovf_err), 64'd0);
      chk_eq("bp_out_valid", 64'(out_valid), 64'd1);
      ready_mode = 2;
      wait_done(300, "bp_done");
      chk_eq("bp_drained", 64'(exp_q.size()), 64'd0);
      chk_eq("bp_no_ovf_end", 64'(ovf_err), 64'd0);

      // overflow: stall ignored, nine rows into an eight-entry FIFO
      ready_mode = 0;
      honour     = 1'b0;
      start_tile(9, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 9; i++) add_row(rand_row(), i < DEPTH);
      repeat (16) step();
      chk_eq("ovf_set", 64'(ovf_err), 64'd1);
      chk_eq("ovf_stall", 64'(array_stall), 64'd1);
      ready_mode = 1;
      n = 0;
      while (out_valid && n < 20) begin
         step();
         n++;
      end
      chk_eq("ovf_drained", 64'(exp_q.size()), 64'd0);
      chk_eq("ovf_empty", 64'(out_valid), 64'd0);
      chk_eq("ovf_still_run", 64'(busy), 64'd1);
      honour = 1'b1;
      ready_mode = 0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      clear_model();
      step();

      // mid-tile reset with rows buffered
      start_tile(10, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 3; i++) add_row(rand_row(), 1'b1);
      repeat (12) step();
      chk_eq("pre_rst_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      step();
      chk_eq("mid_rst_valid", 64'(out_valid), 64'd0);
      chk_eq("mid_rst_busy", 64'(busy), 64'd0);
      chk_eq("mid_rst_errs", 64'({skew_err, ovf_err}), 64'd0);
      chk_eq("mid_rst_stall", 64'(array_stall), 64'd0);
      chk_eq("mid_rst_data", 64'(out_data), 64'd0);
      clear_model();
      rst_n = 1'b1;
      step();

      // random tiles
      ready_mode = 2;
      gaps       = 1'b1;
      for (int t = 0; t < 6; t++) begin
         rows = int'($urandom_range(1, 10));
         start_tile(rows, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         for (int i = 0; i < rows; i++) add_row(rand_row(), 1'b1);
         wait_done(400, "rand_done");
         chk_eq("rand_drained", 64'(exp_q.size()), 64'd0);
         chk_eq("rand_errs", 64'({skew_err, ovf_err}), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
